// File: rtl/soc_ctrl_clk_rst_seq.sv
// soc_ctrl_clk_rst_seq
//   Per-domain clock/reset sequencer. Turns one domain's software clock-enable
//   and reset request plus its PLL lock into an ordered clock-gate enable and
//   active-low domain reset. Reset is always held while the clock starts or
//   stops, and loss of lock drains the domain into FAULT.
//
// Ports
//   clk_i          system clock
//   srst_i         synchronous active-high reset
//   req_arst_n_i   requested domain reset (active-low)
//   req_clk_en_i   requested domain clock enable
//   pll_locked_i   domain PLL lock, already synchronous to clk_i
//   dom_arst_n_o   sequenced domain reset (active-low)
//   dom_clk_en_o   sequenced domain clock-gate enable
//   ready_o        domain running (RUN)
//   fault_o        domain faulted (FAULT)
//   state_o        state encoding for status readback
//
// state     | meaning
// ----------+------------------------------------------------------------
// OFF       | clock gated, reset asserted, idle
// WAIT_LOCK | waiting for LOCK_STABLE_CYC consecutive locked cycles
// HELD      | clock running, reset held for at least RST_HOLD_CYC
// RUN       | clock running, reset released
// DRAIN     | reset asserted, clock kept running CLK_OFF_DLY cycles
// FAULT     | lock timeout or lock loss; clear clk_en request to retry
module soc_ctrl_clk_rst_seq #(
  parameter int unsigned LOCK_STABLE_CYC = 16,
  parameter int unsigned RST_HOLD_CYC    = 8,
  parameter int unsigned CLK_OFF_DLY     = 4,
  parameter int unsigned LOCK_TIMEOUT    = 1024
) (
  input  logic       clk_i,
  input  logic       srst_i,
  input  logic       req_arst_n_i,
  input  logic       req_clk_en_i,
  input  logic       pll_locked_i,
  output logic       dom_arst_n_o,
  output logic       dom_clk_en_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HELD      = 3'd2,
    ST_RUN       = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  localparam int unsigned CNT_MAX =
    (LOCK_STABLE_CYC > RST_HOLD_CYC) ?
      ((LOCK_STABLE_CYC > CLK_OFF_DLY) ? LOCK_STABLE_CYC : CLK_OFF_DLY) :
      ((RST_HOLD_CYC > CLK_OFF_DLY) ? RST_HOLD_CYC : CLK_OFF_DLY);
  localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned TO_W  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(CLK_OFF_DLY - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             fault_pend_q, fault_pend_d;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      to_cnt_q     <= '0;
      fault_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      to_cnt_q     <= to_cnt_d;
      fault_pend_q <= fault_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    to_cnt_d     = to_cnt_q;
    fault_pend_d = fault_pend_q;

    case (state_q)
      ST_OFF: begin
        if (req_clk_en_i) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (!req_clk_en_i) begin
          state_d = ST_OFF;
        end else if (pll_locked_i && (cnt_q == LOCK_LAST)) begin
          state_d = ST_HELD;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = ST_FAULT;
        end else begin
          // Any unlocked cycle restarts the stability window.
          cnt_d    = pll_locked_i ? (cnt_q + 1'b1) : '0;
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (!pll_locked_i) begin
          state_d      = ST_DRAIN;
          fault_pend_d = 1'b1;
        end else if (!req_clk_en_i) begin
          state_d = ST_DRAIN;
        end else if (req_arst_n_i && (cnt_q >= HOLD_LAST)) begin
          state_d = ST_RUN;
        end else if (cnt_q < HOLD_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!pll_locked_i) begin
          state_d      = ST_DRAIN;
          fault_pend_d = 1'b1;
        end else if (!req_clk_en_i) begin
          state_d = ST_DRAIN;
        end else if (!req_arst_n_i) begin
          state_d = ST_HELD;
        end
      end
      ST_DRAIN: begin
        // Requests are ignored so a drain always runs to completion.
        if (cnt_q == OFF_LAST) begin
          state_d      = fault_pend_q ? ST_FAULT : ST_OFF;
          fault_pend_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FAULT: begin
        if (!req_clk_en_i) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase

    if (state_d != state_q) begin
      cnt_d    = '0;
      to_cnt_d = '0;
    end
  end

  always_comb begin
    dom_clk_en_o = 1'b0;
    dom_arst_n_o = 1'b0;
    ready_o      = 1'b0;
    fault_o      = 1'b0;
    case (state_q)
      ST_HELD, ST_DRAIN: dom_clk_en_o = 1'b1;
      ST_RUN: begin
        dom_clk_en_o = 1'b1;
        dom_arst_n_o = 1'b1;
        ready_o      = 1'b1;
      end
      ST_FAULT: fault_o = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_soc_ctrl_clk_rst_seq.sv
module tb_soc_ctrl_clk_rst_seq;

  localparam int S_OFF   = 0;
  localparam int S_WAIT  = 1;
  localparam int S_HELD  = 2;
  localparam int S_RUN   = 3;
  localparam int S_DRAIN = 4;
  localparam int S_FAULT = 5;

  logic       clk_i = 1'b0;
  logic       srst_i = 1'b1;
  logic       req_arst_n_i = 1'b0;
  logic       req_clk_en_i = 1'b0;
  logic       pll_locked_i = 1'b0;
  logic       dom_arst_n_o;
  logic       dom_clk_en_o;
  logic       ready_o;
  logic       fault_o;
  logic [2:0] state_o;

  always #5 clk_i = ~clk_i;

  soc_ctrl_clk_rst_seq dut (
    .clk_i        (clk_i),
    .srst_i       (srst_i),
    .req_arst_n_i (req_arst_n_i),
    .req_clk_en_i (req_clk_en_i),
    .pll_locked_i (pll_locked_i),
    .dom_arst_n_o (dom_arst_n_o),
    .dom_clk_en_o (dom_clk_en_o),
    .ready_o      (ready_o),
    .fault_o      (fault_o),
    .state_o      (state_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: expected {state, clk_en, arst_n, ready, fault}
  logic [6:0] sb_q[$];
  logic prev_clk  = 1'b0;
  logic prev_arst = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_vec(input int st);
    logic ce;
    logic an;
    ce = 1'b0;
    an = 1'b0;
    case (st)
      S_HELD, S_DRAIN: ce = 1'b1;
      S_RUN: begin
        ce = 1'b1;
        an = 1'b1;
      end
      default: ;
    endcase
    return {3'(st), ce, an, (st == S_RUN), (st == S_FAULT)};
  endfunction

  task automatic step(input string tag, input logic srst, input logic en,
                      input logic arst_n, input logic lock, input int exp_st);
    logic [6:0] got;
    logic [6:0] exp;
    @(negedge clk_i);
    srst_i       = srst;
    req_clk_en_i = en;
    req_arst_n_i = arst_n;
    pll_locked_i = lock;
    sb_q.push_back(exp_vec(exp_st));
    @(posedge clk_i);
    #1;
    got = {state_o, dom_clk_en_o, dom_arst_n_o, ready_o, fault_o};
    exp = sb_q.pop_front();
    check_eq(tag, 32'(got), 32'(exp));
    check_eq({tag, "_inv_rise"},
             32'(!prev_clk && dom_clk_en_o && !prev_arst && dom_arst_n_o), 32'd0);
    check_eq({tag, "_inv_fall"},
             32'(!srst && prev_clk && prev_arst && !dom_clk_en_o), 32'd0);
    prev_clk  = dom_clk_en_o;
    prev_arst = dom_arst_n_o;
  endtask

  // Request sampled at the first edge; RUN after LOCK_STABLE + RST_HOLD edges.
  task automatic power_up(input string tag);
    step($sformatf("%s_pu0", tag), 1'b0, 1'b1, 1'b1, 1'b1, S_WAIT);
    for (int k = 1; k <= 24; k++)
      step($sformatf("%s_pu%0d", tag, k), 1'b0, 1'b1, 1'b1, 1'b1,
           (k < 16) ? S_WAIT : ((k < 24) ? S_HELD : S_RUN));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, srst dominates requests
    step("rst0", 1'b1, 1'b0, 1'b0, 1'b0, S_OFF);
    step("rst1", 1'b1, 1'b1, 1'b1, 1'b1, S_OFF);

    // Power-up with stable lock, then stay in RUN
    power_up("a");
    for (int k = 25; k <= 30; k++)
      step($sformatf("a_run%0d", k), 1'b0, 1'b1, 1'b1, 1'b1, S_RUN);

    // One-cycle software reset in RUN: HELD, RUN again 8 edges later
    step("swr0", 1'b0, 1'b1, 1'b0, 1'b1, S_HELD);
    for (int i = 1; i <= 8; i++)
      step($sformatf("swr%0d", i), 1'b0, 1'b1, 1'b1, 1'b1, (i < 8) ? S_HELD : S_RUN);

    // Clock stop from RUN; a request pulse during drain is ignored
    step("stop0", 1'b0, 1'b0, 1'b1, 1'b1, S_DRAIN);
    for (int i = 1; i <= 4; i++)
      step($sformatf("stop%0d", i), 1'b0, (i == 2), 1'b1, 1'b1, (i < 4) ? S_DRAIN : S_OFF);

    // Request withdrawn while waiting for lock
    step("wd0", 1'b0, 1'b1, 1'b1, 1'b0, S_WAIT);
    step("wd1", 1'b0, 1'b0, 1'b1, 1'b0, S_OFF);

    // Lock glitch after 10 locked cycles restarts the stability window
    step("gl0", 1'b0, 1'b1, 1'b1, 1'b1, S_WAIT);
    for (int i = 1; i <= 10; i++)
      step($sformatf("gl_pre%0d", i), 1'b0, 1'b1, 1'b1, 1'b1, S_WAIT);
    step("gl_drop", 1'b0, 1'b1, 1'b1, 1'b0, S_WAIT);
    for (int i = 1; i <= 16; i++)
      step($sformatf("gl_post%0d", i), 1'b0, 1'b1, 1'b1, 1'b1, (i < 16) ? S_WAIT : S_HELD);
    for (int i = 1; i <= 8; i++)
      step($sformatf("gl_hold%0d", i), 1'b0, 1'b1, 1'b1, 1'b1, (i < 8) ? S_HELD : S_RUN);

    // Lock loss in RUN: drain then FAULT; lock recovery alone stays in FAULT
    step("ld0", 1'b0, 1'b1, 1'b1, 1'b0, S_DRAIN);
    for (int i = 1; i <= 4; i++)
      step($sformatf("ld%0d", i), 1'b0, 1'b1, 1'b1, 1'b1, (i < 4) ? S_DRAIN : S_FAULT);
    for (int i = 1; i <= 5; i++)
      step($sformatf("ld_hold%0d", i), 1'b0, 1'b1, 1'b1, 1'b1, S_FAULT);
    step("ld_clr", 1'b0, 1'b0, 1'b1, 1'b1, S_OFF);

    // Lock loss in HELD also ends in FAULT
    step("hl0", 1'b0, 1'b1, 1'b1, 1'b1, S_WAIT);
    for (int i = 1; i <= 16; i++)
      step($sformatf("hl%0d", i), 1'b0, 1'b1, 1'b1, 1'b1, (i < 16) ? S_WAIT : S_HELD);
    step("hl_drop", 1'b0, 1'b1, 1'b1, 1'b0, S_DRAIN);
    for (int i = 1; i <= 4; i++)
      step($sformatf("hl_dr%0d", i), 1'b0, 1'b1, 1'b1, 1'b0, (i < 4) ? S_DRAIN : S_FAULT);
    step("hl_clr", 1'b0, 1'b0, 1'b1, 1'b0, S_OFF);

    // srst while in RUN stops the domain on that edge, no drain
    power_up("b");
    step("srst_run", 1'b1, 1'b1, 1'b1, 1'b1, S_OFF);
    step("srst_rel", 1'b0, 1'b1, 1'b1, 1'b1, S_WAIT);
    step("srst_off", 1'b0, 1'b0, 1'b1, 1'b1, S_OFF);

    // Lock never arrives: FAULT after LOCK_TIMEOUT cycles in WAIT_LOCK
    step("to0", 1'b0, 1'b1, 1'b1, 1'b0, S_WAIT);
    for (int i = 1; i <= 1024; i++)
      step($sformatf("to%0d", i), 1'b0, 1'b1, 1'b1, 1'b0, (i < 1024) ? S_WAIT : S_FAULT);
    step("to_hold", 1'b0, 1'b1, 1'b1, 1'b0, S_FAULT);
    step("to_clr", 1'b0, 1'b0, 1'b1, 1'b0, S_OFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
